uart_hid_source: RTL

UART_HID_SOURCE -- requirements
Module: uart_hid_source

---
 rtl/hid_pkg.sv | 55 +++++
 rtl/uart_hid_source_if.sv | 21 ++
 rtl/uart_rx.sv | 114 +++++++++++
 rtl/uart_hid_source.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/hid_pkg.sv
// hid_pkg: shared definitions for the UART-to-HID keystroke source.
//   - usb_type codes and HID modifier masks
//   - receiver and sequencer state encodings
//   - ascii2scancode(): maps one ASCII byte to a HID usage code and modifier
package hid_pkg;

  localparam logic [1:0] USB_TYPE_NONE     = 2'd0;
  localparam logic [1:0] USB_TYPE_KEYBOARD = 2'd1;
  localparam logic [1:0] USB_TYPE_MOUSE    = 2'd2;

  localparam logic [7:0] MOD_NONE   = 8'h00;
  localparam logic [7:0] MOD_LSHIFT = 8'h02;

  localparam logic [7:0] ASCII_ESC  = 8'h1B;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH
  } rx_state_t;

  typedef enum logic [2:0] {
    SEQ_IDLE, SEQ_PRESS, SEQ_HOLD, SEQ_RELEASE, SEQ_GAP,
    SEQ_M_BTN, SEQ_M_DX, SEQ_M_DY
  } seq_state_t;

  typedef struct packed {
    logic       valid;
    logic [7:0] code;
    logic [7:0] mods;
  } key_map_t;

  function automatic key_map_t ascii2scancode(input logic [7:0] c);
    key_map_t m;
    m.valid = 1'b1;
    m.code  = 8'h00;
    m.mods  = MOD_NONE;
    if (c >= 8'h61 && c <= 8'h7A)      m.code = c - 8'h5D;
    else if (c >= 8'h41 && c <= 8'h5A) begin
      m.code = c - 8'h3D;
      m.mods = MOD_LSHIFT;
    end
    else if (c >= 8'h31 && c <= 8'h39) m.code = c - 8'h13;
    else begin
      case (c)
        8'h30:   m.code = 8'h27;
        8'h0D:   m.code = 8'h28;
        8'h08:   m.code = 8'h2A;
        8'h09:   m.code = 8'h2B;
        8'h20:   m.code = 8'h2C;
        default: m.valid = 1'b0;
      endcase
    end
    return m;
  endfunction

endpackage

// File: rtl/uart_hid_source_if.sv
// uart_hid_source_if: HID report bundle driven by uart_hid_source.
//   usb_type, usb_report (strobe), key_modifiers, key1..key4,
//   mouse_btn, mouse_dx, mouse_dy.
//   master = report producer, slave = report consumer.
interface uart_hid_source_if;
  logic [1:0]        usb_type;
  logic              usb_report;
  logic [7:0]        key_modifiers;
  logic [7:0]        key1;
  logic [7:0]        key2;
  logic [7:0]        key3;
  logic [7:0]        key4;
  logic [7:0]        mouse_btn;
  logic signed [7:0] mouse_dx;
  logic signed [7:0] mouse_dy;

  modport master (output usb_type, usb_report, key_modifiers, key1, key2, key3, key4,
                  mouse_btn, mouse_dx, mouse_dy);
  modport slave  (input  usb_type, usb_report, key_modifiers, key1, key2, key3, key4,
                  mouse_btn, mouse_dx, mouse_dy);
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver with 2-FF input synchronizer, mid-bit sampling.
//   clk, reset (async, active high), rx (raw serial line)
//   data[7:0] (last received byte), valid (1-cycle), frame_err (1-cycle)
//
// state        | meaning
// RX_IDLE      | waiting for a synchronized high-to-low edge
// RX_START     | half a bit later, confirm the start bit is still low
// RX_DATA      | sample 8 data bits at mid-bit, LSB first
// RX_STOP      | sample stop bit; high = byte valid, low = framing error
// RX_WAIT_HIGH | after a framing error, wait for the line to return high
module uart_rx
  import hid_pkg::*;
#(
  parameter int BIT_CYC = 234
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err
);
  localparam int CW = $clog2(BIT_CYC);
  localparam logic [CW-1:0] HALF_LOAD = CW'(BIT_CYC / 2 - 1);
  localparam logic [CW-1:0] BIT_LOAD  = CW'(BIT_CYC - 1);

  rx_state_t   r_state, w_state_nxt;
  logic [1:0]  r_sync;
  logic        r_prev;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]  r_bit, w_bit_nxt;
  logic [7:0]  r_shift, w_shift_nxt;
  logic        r_valid, w_valid_nxt;
  logic        r_err, w_err_nxt;
  logic        w_line, w_fall;

  assign w_line = r_sync[1];
  // r_prev resets low so a line held low through reset cannot look like a start edge.
  assign w_fall = r_prev & ~w_line;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync  <= 2'b00;
      r_prev  <= 1'b0;
      r_state <= RX_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], rx};
      r_prev  <= w_line;
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_valid <= w_valid_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_valid_nxt = 1'b0;
    w_err_nxt   = 1'b0;
    case (r_state)
      RX_IDLE: begin
        if (w_fall) begin
          w_state_nxt = RX_START;
          w_cnt_nxt   = HALF_LOAD;
        end
      end
      RX_START: begin
        if (r_cnt != '0)  w_cnt_nxt = r_cnt - 1'b1;
        else if (!w_line) begin
          w_state_nxt = RX_DATA;
          w_cnt_nxt   = BIT_LOAD;
          w_bit_nxt   = '0;
        end
        else w_state_nxt = RX_IDLE;
      end
      RX_DATA: begin
        if (r_cnt != '0) w_cnt_nxt = r_cnt - 1'b1;
        else begin
          w_shift_nxt = {w_line, r_shift[7:1]};
          w_cnt_nxt   = BIT_LOAD;
          w_bit_nxt   = r_bit + 1'b1;
          if (r_bit == 3'd7) w_state_nxt = RX_STOP;
        end
      end
      RX_STOP: begin
        if (r_cnt != '0) w_cnt_nxt = r_cnt - 1'b1;
        else if (w_line) begin
          w_valid_nxt = 1'b1;
          w_state_nxt = RX_IDLE;
        end else begin
          w_err_nxt   = 1'b1;
          w_state_nxt = RX_WAIT_HIGH;
        end
      end
      RX_WAIT_HIGH: if (w_line) w_state_nxt = RX_IDLE;
      default: w_state_nxt = RX_IDLE;
    endcase
  end

  assign data      = r_shift;
  assign valid     = r_valid;
  assign frame_err = r_err;

endmodule

// File: rtl/uart_hid_source.sv
// uart_hid_source: turns ASCII bytes received over UART into HID keyboard
// press/release reports (and, optionally, mouse reports).
//   clk, reset (async, active high), uart_rx (8N1, idle high)
//   rpt     : HID report bundle (uart_hid_source_if.master)
//   rx_err  : 1-cycle pulse on a framing error
//   rx_ovf  : sticky, a byte was dropped on a full FIFO
// Optional feature macro: MOUSE_CMD_EN -- 0x1B followed by btn, dx, dy
// produces a single mouse report.
//
// state       | meaning
// SEQ_IDLE    | pop a byte when available; unmapped bytes are dropped here
// SEQ_PRESS   | press report is on the outputs this cycle
// SEQ_HOLD    | key held; release strobe lands HOLD_CYCLES after press
// SEQ_RELEASE | release report is on the outputs this cycle
// SEQ_GAP     | HOLD_CYCLES quiet cycles so repeated keys stay distinct
// SEQ_M_BTN   | collect mouse button byte
// SEQ_M_DX    | collect mouse dx byte
// SEQ_M_DY    | collect mouse dy byte, then strobe the mouse report
module uart_hid_source
  import hid_pkg::*;
#(
  parameter int CLK_FREQ    = 27000000,
  parameter int BAUD        = 115200,
  parameter int HOLD_CYCLES = 270000,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               uart_rx,
  uart_hid_source_if.master  rpt,
  output logic               rx_err,
  output logic               rx_ovf
);
  localparam int BIT_CYC = CLK_FREQ / BAUD;
  localparam int AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW      = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 2);
  localparam logic [CW-1:0] GAP_LOAD  = CW'(HOLD_CYCLES - 1);

  logic [7:0] w_rx_data;
  logic       w_rx_valid;

  uart_rx #(.BIT_CYC(BIT_CYC)) u_rx (
    .clk       (clk),
    .reset     (reset),
    .rx        (uart_rx),
    .data      (w_rx_data),
    .valid     (w_rx_valid),
    .frame_err (rx_err)
  );

  logic [7:0]  r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0] r_count;
  logic        r_rx_ovf;
  logic        w_full, w_empty, w_push, w_pop;
  logic [7:0]  w_head;

  assign w_full  = (r_count == (AW+1)'(FIFO_DEPTH));
  assign w_empty = (r_count == '0);
  // A same-cycle pop frees a slot, so a full FIFO still accepts the byte.
  assign w_push  = w_rx_valid & (~w_full | w_pop);
  assign w_head  = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_rx_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_rx_ovf <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
      if (w_rx_valid && !w_push) r_rx_ovf <= 1'b1;
    end
  end

  assign rx_ovf = r_rx_ovf;

  seq_state_t    r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [1:0]    r_type, w_type_nxt;
  logic          r_report, w_report_nxt;
  logic [7:0]    r_mods, w_mods_nxt;
  logic [7:0]    r_key1, w_key1_nxt;
  key_map_t      w_map;
`ifdef MOUSE_CMD_EN
  logic [7:0]    r_btn, w_btn_nxt;
  logic [7:0]    r_dx, w_dx_nxt;
  logic [7:0]    r_dy, w_dy_nxt;
`endif

  assign w_map = ascii2scancode(w_head);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= SEQ_IDLE;
      r_cnt    <= '0;
      r_type   <= USB_TYPE_NONE;
      r_report <= 1'b0;
      r_mods   <= MOD_NONE;
      r_key1   <= '0;
`ifdef MOUSE_CMD_EN
      r_btn    <= '0;
      r_dx     <= '0;
      r_dy     <= '0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_type   <= w_type_nxt;
      r_report <= w_report_nxt;
      r_mods   <= w_mods_nxt;
      r_key1   <= w_key1_nxt;
`ifdef MOUSE_CMD_EN
      r_btn    <= w_btn_nxt;
      r_dx     <= w_dx_nxt;
      r_dy     <= w_dy_nxt;
`endif
    end
  end

  // Report fields are registered on the transition edge, so the strobe is
  // visible during the PRESS / RELEASE cycle itself.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_type_nxt   = r_type;
    w_report_nxt = 1'b0;
    w_mods_nxt   = r_mods;
    w_key1_nxt   = r_key1;
    w_pop        = 1'b0;
`ifdef MOUSE_CMD_EN
    w_btn_nxt    = r_btn;
    w_dx_nxt     = r_dx;
    w_dy_nxt     = r_dy;
`endif
    case (r_state)
      SEQ_IDLE: begin
        if (!w_empty) begin
          w_pop = 1'b1;
          if (w_map.valid) begin
            w_state_nxt  = SEQ_PRESS;
            w_report_nxt = 1'b1;
            w_type_nxt   = USB_TYPE_KEYBOARD;
            w_key1_nxt   = w_map.code;
            w_mods_nxt   = w_map.mods;
          end
`ifdef MOUSE_CMD_EN
          else if (w_head == ASCII_ESC) w_state_nxt = SEQ_M_BTN;
`endif
        end
      end
      SEQ_PRESS: begin
        w_state_nxt = SEQ_HOLD;
        w_cnt_nxt   = HOLD_LOAD;
      end
      SEQ_HOLD: begin
        if (r_cnt != '0) w_cnt_nxt = r_cnt - 1'b1;
        else begin
          w_state_nxt  = SEQ_RELEASE;
          w_report_nxt = 1'b1;
          w_type_nxt   = USB_TYPE_KEYBOARD;
          w_key1_nxt   = '0;
          w_mods_nxt   = MOD_NONE;
        end
      end
      SEQ_RELEASE: begin
        w_state_nxt = SEQ_GAP;
        w_cnt_nxt   = GAP_LOAD;
      end
      SEQ_GAP: begin
        if (r_cnt != '0) w_cnt_nxt = r_cnt - 1'b1;
        else             w_state_nxt = SEQ_IDLE;
      end
`ifdef MOUSE_CMD_EN
      SEQ_M_BTN: if (!w_empty) begin
        w_pop       = 1'b1;
        w_btn_nxt   = w_head;
        w_state_nxt = SEQ_M_DX;
      end
      SEQ_M_DX: if (!w_empty) begin
        w_pop       = 1'b1;
        w_dx_nxt    = w_head;
        w_state_nxt = SEQ_M_DY;
      end
      SEQ_M_DY: if (!w_empty) begin
        w_pop        = 1'b1;
        w_dy_nxt     = w_head;
        w_report_nxt = 1'b1;
        w_type_nxt   = USB_TYPE_MOUSE;
        w_state_nxt  = SEQ_IDLE;
      end
`endif
      default: w_state_nxt = SEQ_IDLE;
    endcase
  end

  assign rpt.usb_type      = r_type;
  assign rpt.usb_report    = r_report;
  assign rpt.key_modifiers = r_mods;
  assign rpt.key1          = r_key1;
  assign rpt.key2          = '0;
  assign rpt.key3          = '0;
  assign rpt.key4          = '0;
`ifdef MOUSE_CMD_EN
  assign rpt.mouse_btn     = r_btn;
  assign rpt.mouse_dx      = r_dx;
  assign rpt.mouse_dy      = r_dy;
`else
  assign rpt.mouse_btn     = '0;
  assign rpt.mouse_dx      = '0;
  assign rpt.mouse_dy      = '0;
`endif

endmodule
